// File: rtl/fib_regfile_sequencer_pkg.sv
// Shared definitions for the Fibonacci register-file sequencer: ALU opcodes,
// controller state encoding and the run-length clamp helper.
package fib_regfile_sequencer_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_PASSB = 4'b1101;
  localparam logic [3:0] OP_OR    = 4'b0011;

  typedef enum logic [2:0] {
    StIdle,
    StInit0,
    StInit1,
    StAdd,
    StDone,
    StErr
  } state_e;

  // Limit a requested term count to [2, nreg]; fewer than two terms makes no sense
  // because r0 and r1 are always seeded.
  function automatic int unsigned clamp_terms(int unsigned n, int unsigned nreg);
    if (n < 2) begin
      return 2;
    end else if (n > nreg) begin
      return nreg;
    end
    return n;
  endfunction

endpackage

// File: rtl/fib_regfile_sequencer.sv
// Counter-driven controller that fills r0..r(n-1) of an external register file
// with Fibonacci terms via an external ALU, with start/busy/done handshake and
// sticky overflow error on ALU carry-out.
module fib_regfile_sequencer
  import fib_regfile_sequencer_pkg::*;
#(
  parameter int unsigned NREG = 16,
  parameter int unsigned AW   = 4,
  parameter int unsigned DW   = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [AW:0]   num_terms,
  input  logic [AW-1:0] disp_sel,
  input  logic          alu_cout,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [AW-1:0] rf_ra_a,
  output logic [AW-1:0] rf_ra_b,
  output logic [3:0]    alu_op,
  output logic          imm_sel,
  output logic [DW-1:0] imm,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned KW = AW + 1;

  state_e        state_q, state_d;
  logic [AW:0]   k_q, k_d;
  logic [AW:0]   n_lat_q, n_lat_d;
  logic [AW:0]   n_clamped;
  logic          last_term;

  assign n_clamped = KW'(clamp_terms(32'(num_terms), NREG));
  assign last_term = (k_q == (n_lat_q - KW'(1)));

  // Next-state: start is only honoured from the resting states.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_lat_d = n_lat_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StInit0;
          n_lat_d = n_clamped;
        end
      end
      StInit0: begin
        state_d = StInit1;
      end
      StInit1: begin
        k_d     = KW'(2);
        state_d = (n_lat_q == KW'(2)) ? StDone : StAdd;
      end
      StAdd: begin
        // The wrapped sum is still written this cycle; we just stop afterwards.
        if (alu_cout) begin
          state_d = StErr;
        end else if (last_term) begin
          state_d = StDone;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, loop counter and latched term count; clr overrides everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      k_q     <= '0;
      n_lat_q <= KW'(2);
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_lat_q <= n_lat_d;
    end
  end

  // Moore output decode of state and k.
  always_comb begin
    rf_we   = 1'b0;
    rf_wa   = '0;
    rf_ra_a = disp_sel;
    rf_ra_b = '0;
    alu_op  = OP_PASSB;
    imm_sel = 1'b0;
    imm     = '0;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      StIdle: begin
      end
      StInit0: begin
        rf_we   = 1'b1;
        rf_wa   = '0;
        rf_ra_a = '0;
        imm_sel = 1'b1;
        imm     = DW'(1);
        busy    = 1'b1;
      end
      StInit1: begin
        rf_we   = 1'b1;
        rf_wa   = AW'(1);
        rf_ra_a = '0;
        imm_sel = 1'b1;
        imm     = DW'(1);
        busy    = 1'b1;
      end
      StAdd: begin
        rf_we   = 1'b1;
        rf_wa   = k_q[AW-1:0];
        rf_ra_a = k_q[AW-1:0] - AW'(1);
        rf_ra_b = k_q[AW-1:0] - AW'(2);
        alu_op  = OP_ADD;
        busy    = 1'b1;
      end
      StDone: begin
        done = 1'b1;
      end
      StErr: begin
        err = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fib_regfile_sequencer.sv
// Bench: two sequencer instances (16-bit and 8-bit datapath) sharing control
// inputs, each driving its own behavioural regfile and ALU.
module tb_fib_regfile_sequencer;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic [4:0] num_terms = 5'd2;
  logic [3:0] disp_sel = 4'd0;
  logic       preload = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 16-bit datapath instance
  logic        we16, imm_sel16, busy16, done16, err16, cout16;
  logic [3:0]  wa16, ra_a16, ra_b16, op16;
  logic [15:0] imm16, b16, res16;
  logic [15:0] rf16 [16];

  // 8-bit datapath instance
  logic        we8, imm_sel8, busy8, done8, err8, cout8;
  logic [3:0]  wa8, ra_a8, ra_b8, op8;
  logic [7:0]  imm8, b8, res8;
  logic [7:0]  rf8 [16];

  fib_regfile_sequencer #(.NREG(16), .AW(4), .DW(16)) u_dut16 (
    .clk(clk), .clr(clr), .start(start), .num_terms(num_terms), .disp_sel(disp_sel),
    .alu_cout(cout16), .rf_we(we16), .rf_wa(wa16), .rf_ra_a(ra_a16), .rf_ra_b(ra_b16),
    .alu_op(op16), .imm_sel(imm_sel16), .imm(imm16), .busy(busy16), .done(done16),
    .err(err16)
  );

  fib_regfile_sequencer #(.NREG(16), .AW(4), .DW(8)) u_dut8 (
    .clk(clk), .clr(clr), .start(start), .num_terms(num_terms), .disp_sel(disp_sel),
    .alu_cout(cout8), .rf_we(we8), .rf_wa(wa8), .rf_ra_a(ra_a8), .rf_ra_b(ra_b8),
    .alu_op(op8), .imm_sel(imm_sel8), .imm(imm8), .busy(busy8), .done(done8),
    .err(err8)
  );

  // Behavioural ALUs: 4'b0101 = ADD with carry-out, anything else passes B.
  always_comb begin
    b16 = imm_sel16 ? imm16 : rf16[ra_b16];
    if (op16 == 4'b0101) {cout16, res16} = {1'b0, rf16[ra_a16]} + {1'b0, b16};
    else {cout16, res16} = {1'b0, b16};
    b8 = imm_sel8 ? imm8 : rf8[ra_b8];
    if (op8 == 4'b0101) {cout8, res8} = {1'b0, rf8[ra_a8]} + {1'b0, b8};
    else {cout8, res8} = {1'b0, b8};
  end

  // Behavioural regfiles with a bench-side preload pattern.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) begin
        rf16[i] <= 16'hA500 + 16'(i);
        rf8[i]  <= 8'h50 + 8'(i);
      end
    end else begin
      if (we16) rf16[wa16] <= res16;
      if (we8)  rf8[wa8]   <= res8;
    end
  end

  logic [15:0] fib [16];
  initial begin
    fib = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34, 16'd55,
            16'd89, 16'd144, 16'd233, 16'd377, 16'd610, 16'd987};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_preload();
    preload = 1'b1;
    tick();
    preload = 1'b0;
  endtask

  // Pulse start for one edge (edge 0).
  task automatic kick(input logic [4:0] n);
    start     = 1'b1;
    num_terms = n;
    tick();
    start     = 1'b0;
  endtask

  // Count edges after edge 0 until done/err on the chosen instance, bounded.
  task automatic wait_end(input bit use8, output int edges);
    edges = 0;
    while (!(use8 ? (done8 || err8) : (done16 || err16)) && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    clr   = 1'b1;
    start = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy16, done16, err16, we16} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {busy16, done16, err16, we16});
    end
    checks++;
    if ({op16, imm_sel16, imm16} !== {4'b1101, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_alu: got op=%b sel=%b imm=%0d expected op=1101 sel=0 imm=0",
               op16, imm_sel16, imm16);
    end
    checks++;
    if ({wa16, ra_b16, ra_a16} !== {4'd0, 4'd0, disp_sel}) begin
      errors++;
      $display("FAIL reset_addr: got wa=%0d rb=%0d ra=%0d expected 0 0 %0d",
               wa16, ra_b16, ra_a16, disp_sel);
    end
    clr   = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy16 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_hold: busy got %b expected 0", busy16);
    end
  endtask

  task automatic test_full_run();
    int edges;
    do_preload();
    kick(5'd16);
    checks++;
    if ({busy16, we16, imm_sel16, wa16} !== {3'b111, 4'd0}) begin
      errors++;
      $display("FAIL init0_decode: got %b expected 1110000", {busy16, we16, imm_sel16, wa16});
    end
    wait_end(1'b0, edges);
    checks++;
    if (edges !== 16) begin
      errors++;
      $display("FAIL full_latency: got %0d edges expected 16", edges);
    end
    checks++;
    if ({done16, err16, busy16} !== 3'b100) begin
      errors++;
      $display("FAIL full_flags: got %b expected 100", {done16, err16, busy16});
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rf16[i] !== fib[i]) begin
        errors++;
        $display("FAIL full_r%0d: got %0d expected %0d", i, rf16[i], fib[i]);
      end
    end
  endtask

  task automatic test_short_run();
    int edges;
    do_preload();
    kick(5'd5);
    wait_end(1'b0, edges);
    checks++;
    if (edges !== 5) begin
      errors++;
      $display("FAIL short_latency: got %0d edges expected 5", edges);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rf16[i] !== ((i < 5) ? fib[i] : 16'hA500 + 16'(i))) begin
        errors++;
        $display("FAIL short_r%0d: got %h", i, rf16[i]);
      end
    end
    disp_sel = 4'd4;
    #1;
    checks++;
    if (ra_a16 !== 4'd4) begin
      errors++;
      $display("FAIL short_disp: got %0d expected 4", ra_a16);
    end
    disp_sel = 4'd0;
  endtask

  task automatic test_overflow();
    int edges;
    do_preload();
    kick(5'd16);
    wait_end(1'b1, edges);
    checks++;
    if (edges !== 14) begin
      errors++;
      $display("FAIL ovf_latency: got %0d edges expected 14", edges);
    end
    checks++;
    if ({err8, done8, busy8} !== 3'b100) begin
      errors++;
      $display("FAIL ovf_flags: got %b expected 100", {err8, done8, busy8});
    end
    checks++;
    if ({rf8[12], rf8[13], rf8[14], rf8[15]} !== {8'd233, 8'd121, 8'h5E, 8'h5F}) begin
      errors++;
      $display("FAIL ovf_regs: got %0d %0d %h %h expected 233 121 5e 5f",
               rf8[12], rf8[13], rf8[14], rf8[15]);
    end
    repeat (4) tick();
    checks++;
    if (err8 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b expected 1", err8);
    end
    // A new start clears the sticky error.
    kick(5'd2);
    checks++;
    if ({err8, busy8} !== 2'b01) begin
      errors++;
      $display("FAIL ovf_restart: got %b expected 01", {err8, busy8});
    end
    wait_end(1'b0, edges);
  endtask

  task automatic test_clamp();
    int edges;
    do_preload();
    kick(5'd0);
    wait_end(1'b0, edges);
    checks++;
    if (edges !== 2) begin
      errors++;
      $display("FAIL clamp_lo_latency: got %0d edges expected 2", edges);
    end
    checks++;
    if ({rf16[0], rf16[1], rf16[2]} !== {16'd1, 16'd1, 16'hA502}) begin
      errors++;
      $display("FAIL clamp_lo_regs: got %h %h %h", rf16[0], rf16[1], rf16[2]);
    end
    kick(5'd31);
    wait_end(1'b0, edges);
    checks++;
    if (edges !== 16) begin
      errors++;
      $display("FAIL clamp_hi_latency: got %0d edges expected 16", edges);
    end
    checks++;
    if (rf16[15] !== 16'd987) begin
      errors++;
      $display("FAIL clamp_hi_r15: got %0d expected 987", rf16[15]);
    end
  endtask

  task automatic test_clr_mid_run();
    int edges;
    kick(5'd16);
    repeat (7) tick();
    checks++;
    if ({busy16, wa16, ra_a16, ra_b16} !== {1'b1, 4'd7, 4'd6, 4'd5}) begin
      errors++;
      $display("FAIL clr_add_k7: got busy=%b wa=%0d ra=%0d rb=%0d expected 1 7 6 5",
               busy16, wa16, ra_a16, ra_b16);
    end
    clr   = 1'b1;
    start = 1'b1;
    tick();
    checks++;
    if ({busy16, we16, done16, err16} !== 4'b0000) begin
      errors++;
      $display("FAIL clr_idle: got %b expected 0000", {busy16, we16, done16, err16});
    end
    clr   = 1'b0;
    start = 1'b0;
    tick();
    do_preload();
    kick(5'd5);
    wait_end(1'b0, edges);
    checks++;
    if (edges !== 5) begin
      errors++;
      $display("FAIL clr_rerun_latency: got %0d edges expected 5", edges);
    end
    checks++;
    if ({rf16[3], rf16[4], rf16[5]} !== {16'd3, 16'd5, 16'hA505}) begin
      errors++;
      $display("FAIL clr_rerun_regs: got %h %h %h", rf16[3], rf16[4], rf16[5]);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    do_preload();
    kick(5'd6);
    tick();
    start     = 1'b1;
    num_terms = 5'd16;
    tick();
    tick();
    start = 1'b0;
    wait_end(1'b0, edges);
    checks++;
    if (edges + 3 !== 6) begin
      errors++;
      $display("FAIL b2b_latency: got %0d edges expected 6", edges + 3);
    end
    checks++;
    if ({rf16[5], rf16[6]} !== {16'd8, 16'hA506}) begin
      errors++;
      $display("FAIL b2b_regs: got %h %h expected 0008 a506", rf16[5], rf16[6]);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_short_run();
    test_overflow();
    test_clamp();
    test_clr_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
